// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART PIPO FIFO.
package uart_pkg;

    localparam int unsigned UART_WORD_W = 16;

    typedef logic [UART_WORD_W-1:0] uart_word_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_fifo_ptr.sv
// Wrapping FIFO pointer with enable, synchronous clear and increment.
module uart_fifo_ptr #(
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            if (clr) begin
                ptr_d = '0;
            end else if (inc) begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/uart_pipo_fifo.sv
// First-word-fall-through FIFO between the UART datapath and the host FSM,
// with occupancy count, full/empty status and sticky overflow/underflow flags.
module uart_pipo_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       Sync_Reset,
    input  logic                       push,
    input  logic [WORD_LENGTH-1:0]     Data_Input,
    input  logic                       pop,
    output logic [WORD_LENGTH-1:0]     Data_Output,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [WORD_LENGTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;

    logic empty_c;
    logic full_c;
    logic push_acc_c;
    logic pop_acc_c;
    logic wr_en_c;
    logic rd_en_c;
    logic clr_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNT_W'(DEPTH));

    // A push into a full FIFO is still accepted when a pop frees the head slot.
    assign push_acc_c = push && (!full_c || pop);
    assign pop_acc_c  = pop && !empty_c;
    assign clr_c      = enable && Sync_Reset;
    assign wr_en_c    = enable && !Sync_Reset && push_acc_c;
    assign rd_en_c    = enable && !Sync_Reset && pop_acc_c;

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (enable) begin
            if (Sync_Reset) begin
                count_d     = '0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end else begin
                count_d = count_q + CNT_W'(push_acc_c) - CNT_W'(pop_acc_c);
                if (push && !pop && full_c) begin
                    overflow_d = 1'b1;
                end
                if (pop && empty_c) begin
                    underflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally not reset; the empty gate hides stale words.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr] <= Data_Input;
        end
    end

    uart_fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (reset),
        .en    (enable),
        .clr   (clr_c),
        .inc   (wr_en_c),
        .ptr   (wr_ptr)
    );

    uart_fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (reset),
        .en    (enable),
        .clr   (clr_c),
        .inc   (rd_en_c),
        .ptr   (rd_ptr)
    );

    assign Data_Output = empty_c ? '0 : mem_q[rd_ptr];
    assign empty       = empty_c;
    assign full        = full_c;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_uart_pipo_fifo.sv
// Directed self-checking bench for uart_pipo_fifo (WORD_LENGTH=16, DEPTH=8).
module tb_uart_pipo_fifo;

    localparam int unsigned WL    = 16;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          Sync_Reset;
    logic          push;
    logic [WL-1:0] Data_Input;
    logic          pop;
    logic [WL-1:0] Data_Output;
    logic          empty;
    logic          full;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fails  = 0;

    uart_pipo_fifo #(.WORD_LENGTH(WL), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .Sync_Reset  (Sync_Reset),
        .push        (push),
        .Data_Input  (Data_Input),
        .pop         (pop),
        .Data_Output (Data_Output),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic p, input logic [WL-1:0] d, input logic q);
        push       = p;
        Data_Input = d;
        pop        = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic sclear();
        Sync_Reset = 1'b1;
        step(1'b0, '0, 1'b0);
        Sync_Reset = 1'b0;
    endtask

    task automatic check_status(input string tag, input int c, input logic ov, input logic un);
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_empty"}, 32'(empty), 32'(c == 0));
        check({tag, "_full"}, 32'(full), 32'(c == DEPTH));
        check({tag, "_ovf"}, 32'(overflow), 32'(ov));
        check({tag, "_unf"}, 32'(underflow), 32'(un));
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b1;
        Sync_Reset = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        Data_Input = '0;
        repeat (2) @(posedge clk);
        #1;
        check_status("por", 0, 1'b0, 1'b0);
        check("por_dout", 32'(Data_Output), 32'h0);
        reset = 1'b1;

        // 1. async reset mid-traffic
        step(1'b0, '0, 1'b1);
        check("t1_unf_set", 32'(underflow), 32'h1);
        step(1'b1, 16'h0011, 1'b0);
        check("t1_latency", 32'(Data_Output), 32'h0011);
        step(1'b1, 16'h0022, 1'b0);
        check_status("t1_pre", 2, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_status("t1_rst", 0, 1'b0, 1'b0);
        check("t1_rst_dout", 32'(Data_Output), 32'h0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 2. fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) step(1'b1, WL'(i), 1'b0);
        check_status("t2_full", 8, 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0);
        check_status("t2_ovf", 8, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t2_pop%0d", i), 32'(Data_Output), 32'(i));
            step(1'b0, '0, 1'b1);
        end
        check_status("t2_drained", 0, 1'b1, 1'b0);
        check("t2_dout0", 32'(Data_Output), 32'h0);
        sclear();

        // 3. pointer wrap
        for (int i = 0; i < 5; i++) step(1'b1, WL'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        check_status("t3_mid", 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, WL'(16'hA000 + i), 1'b0);
        check_status("t3_full", 8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_pop%0d", i), 32'(Data_Output), 32'(16'hA000 + i));
            step(1'b0, '0, 1'b1);
        end
        check("t3_empty", 32'(empty), 32'h1);

        // 4. simultaneous push/pop on full
        for (int i = 0; i < 8; i++) step(1'b1, WL'(16'h0010 + i), 1'b0);
        step(1'b1, 16'h1234, 1'b1);
        check_status("t4_pp", 8, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("t4_pop%0d", i), 32'(Data_Output), 32'(16'h0010 + i));
            step(1'b0, '0, 1'b1);
        end
        check("t4_last", 32'(Data_Output), 32'h1234);
        step(1'b0, '0, 1'b1);
        check_status("t4_end", 0, 1'b0, 1'b0);

        // 5. simultaneous push/pop on empty
        step(1'b1, 16'h00FF, 1'b1);
        check_status("t5", 1, 1'b0, 1'b1);
        check("t5_dout", 32'(Data_Output), 32'h00FF);

        // 6. enable low freezes everything, then sync clear beats push
        enable = 1'b0;
        Sync_Reset = 1'b1;
        step(1'b1, 16'h7777, 1'b0);
        Sync_Reset = 1'b0;
        step(1'b0, '0, 1'b1);
        step(1'b1, 16'h6666, 1'b1);
        check_status("t6_frozen", 1, 1'b0, 1'b1);
        check("t6_frozen_dout", 32'(Data_Output), 32'h00FF);
        enable = 1'b1;
        Sync_Reset = 1'b1;
        step(1'b1, 16'hDEAD, 1'b0);
        Sync_Reset = 1'b0;
        check_status("t6_sclr", 0, 1'b0, 1'b0);
        check("t6_sclr_dout", 32'(Data_Output), 32'h0);
        step(1'b1, 16'h5555, 1'b0);
        check_status("t6_after", 1, 1'b0, 1'b0);
        check("t6_after_dout", 32'(Data_Output), 32'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
